// File: rtl/arch_dpram_pkg.sv
// Shared sizing constants and types for the 4x4 dual-read-port register-file RAM.
package arch_dpram_pkg;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned OUT_W    = 16;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned WR_A_BIT = 1;
  localparam int unsigned WR_B_BIT = 0;

  typedef logic [DATA_W-1:0]            word_t;
  typedef logic [OUT_W-1:0]             out_t;
  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  function automatic out_t zext(input word_t w);
    out_t r;
    r             = '0;
    r[DATA_W-1:0] = w;
    return r;
  endfunction

endpackage

// File: rtl/arch_dpram_rd_port.sv
// Registered read port: when enabled, captures the addressed word zero-extended
// onto the output bus; otherwise holds the last value.
module arch_dpram_rd_port
  import arch_dpram_pkg::*;
(
  input  logic                         clck,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            rd_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  output logic [OUT_W-1:0]             data_out
);

  out_t data_out_q;
  out_t data_out_d;

  always_comb begin
    data_out_d = data_out_q;
    if (rd_en) begin
      data_out_d = zext(mem[rd_addr]);
    end
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/arch_dpram.sv
// 4-word x 4-bit scratch RAM: one shared write address with two data sources
// (port A has priority), plus two independent registered read ports.
module arch_dpram
  import arch_dpram_pkg::*;
(
  input  logic              clck,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        write,
  input  logic              read_a,
  input  logic              read_b,
  input  logic [ADDR_W-1:0] address_read_a,
  input  logic [ADDR_W-1:0] address_read_b,
  output logic [OUT_W-1:0]  data_out_a,
  output logic [OUT_W-1:0]  data_out_b
);

  mem_t mem_q;
  mem_t mem_d;

  // Read ports sample mem_q, so a same-cycle write is seen only on the next read.
  always_comb begin
    mem_d = mem_q;
    if (write[WR_A_BIT]) begin
      mem_d[address] = data_a;
    end else if (write[WR_B_BIT]) begin
      mem_d[address] = data_b;
    end
  end

  always_ff @(posedge clck or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  arch_dpram_rd_port u_rd_a (
    .clck     (clck),
    .rst      (rst),
    .rd_en    (read_a),
    .rd_addr  (address_read_a),
    .mem      (mem_q),
    .data_out (data_out_a)
  );

  arch_dpram_rd_port u_rd_b (
    .clck     (clck),
    .rst      (rst),
    .rd_en    (read_b),
    .rd_addr  (address_read_b),
    .mem      (mem_q),
    .data_out (data_out_b)
  );

endmodule

// File: tb/tb_arch_dpram.sv
// Scoreboard bench for arch_dpram: a behavioural memory model produces read
// expectations that are queued at issue time and checked one edge later.
module tb_arch_dpram;
  import arch_dpram_pkg::*;

  logic              clck = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] data_a;
  logic [DATA_W-1:0] data_b;
  logic [ADDR_W-1:0] address;
  logic [1:0]        write;
  logic              read_a;
  logic              read_b;
  logic [ADDR_W-1:0] address_read_a;
  logic [ADDR_W-1:0] address_read_b;
  logic [OUT_W-1:0]  data_out_a;
  logic [OUT_W-1:0]  data_out_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [OUT_W-1:0]  q_a [$];
  logic [OUT_W-1:0]  q_b [$];
  logic [OUT_W-1:0]  last_a;
  logic [OUT_W-1:0]  last_b;

  arch_dpram dut (
    .clck           (clck),
    .rst            (rst),
    .data_a         (data_a),
    .data_b         (data_b),
    .address        (address),
    .write          (write),
    .read_a         (read_a),
    .read_b         (read_b),
    .address_read_a (address_read_a),
    .address_read_b (address_read_b),
    .data_out_a     (data_out_a),
    .data_out_b     (data_out_b)
  );

  always #5 clck = ~clck;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [OUT_W-1:0] got,
                          input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    last_a = '0;
    last_b = '0;
  endtask

  // One clock: drive inputs, queue read expectations from the pre-edge model,
  // then after the edge apply the write to the model and score the outputs.
  task automatic cyc(input logic [1:0] wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                     input logic ra, input logic [ADDR_W-1:0] aa,
                     input logic rb, input logic [ADDR_W-1:0] ab);
    logic [OUT_W-1:0] exp;
    write = wr; address = addr; data_a = da; data_b = db;
    read_a = ra; address_read_a = aa; read_b = rb; address_read_b = ab;
    if (ra) q_a.push_back(OUT_W'(model[aa]));
    if (rb) q_b.push_back(OUT_W'(model[ab]));
    @(posedge clck);
    #1;
    if (wr[1]) model[addr] = da;
    else if (wr[0]) model[addr] = db;
    if (ra) begin
      exp = q_a.pop_front();
      check_eq("rd_a", data_out_a, exp);
      last_a = exp;
    end else begin
      check_eq("hold_a", data_out_a, last_a);
    end
    if (rb) begin
      exp = q_b.pop_front();
      check_eq("rd_b", data_out_b, exp);
      last_b = exp;
    end else begin
      check_eq("hold_b", data_out_b, last_b);
    end
    write = 2'b00; read_a = 1'b0; read_b = 1'b0;
  endtask

  initial begin
    // Reset held across edges with write/read activity that must be ignored.
    rst = 1'b1;
    data_a = 4'hF; data_b = 4'h5; address = '0; write = 2'b11;
    read_a = 1'b1; read_b = 1'b1; address_read_a = '0; address_read_b = '0;
    repeat (2) @(posedge clck);
    #1;
    check_eq("rst_out_a", data_out_a, 16'h0000);
    check_eq("rst_out_b", data_out_b, 16'h0000);
    write = 2'b00; read_a = 1'b0; read_b = 1'b0;
    rst = 1'b0;
    model_clear();

    for (int i = 0; i < int'(DEPTH); i++)
      cyc(2'b00, '0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(i));

    cyc(2'b10, 2'd0, 4'b1010, 4'b0000, 1'b0, '0, 1'b0, '0);
    cyc(2'b01, 2'd1, 4'b0000, 4'b1100, 1'b0, '0, 1'b0, '0);
    cyc(2'b10, 2'd2, 4'b0110, 4'b0000, 1'b0, '0, 1'b0, '0);
    cyc(2'b01, 2'd3, 4'b0000, 4'b1111, 1'b0, '0, 1'b0, '0);

    for (int i = 0; i < int'(DEPTH); i++)
      cyc(2'b00, '0, '0, '0, 1'b1, ADDR_W'(i), 1'b0, '0);
    check_eq("tp_a3", data_out_a, 16'h000F);

    for (int i = 0; i < int'(DEPTH); i++)
      cyc(2'b00, '0, '0, '0, 1'b0, '0, 1'b1, ADDR_W'(i));
    check_eq("tp_b3", data_out_b, 16'h000F);
    check_eq("tp_hold_a", data_out_a, 16'h000F);

    // Both ports on the same word.
    cyc(2'b00, '0, '0, '0, 1'b1, 2'd1, 1'b1, 2'd1);
    check_eq("same_addr_a", data_out_a, 16'h000C);

    // Collision: port A wins.
    cyc(2'b11, 2'd2, 4'b0011, 4'b0101, 1'b0, '0, 1'b0, '0);
    cyc(2'b00, '0, '0, '0, 1'b1, 2'd2, 1'b1, 2'd2);
    check_eq("collision", data_out_a, 16'h0003);

    // Read-during-write returns old contents.
    cyc(2'b10, 2'd1, 4'b0111, 4'b0000, 1'b1, 2'd1, 1'b0, '0);
    check_eq("rdw_old", data_out_a, 16'h000C);
    cyc(2'b00, '0, '0, '0, 1'b1, 2'd1, 1'b0, '0);
    check_eq("rdw_new", data_out_a, 16'h0007);

    // A few random mixed cycles against the model.
    for (int i = 0; i < 40; i++)
      cyc(2'($urandom_range(0, 3)), ADDR_W'($urandom), DATA_W'($urandom),
          DATA_W'($urandom), 1'($urandom), ADDR_W'($urandom),
          1'($urandom), ADDR_W'($urandom));

    // Async reset pulsed between edges.
    cyc(2'b00, '0, '0, '0, 1'b1, 2'd0, 1'b1, 2'd3);
    cyc(2'b10, 2'd3, 4'h9, 4'h0, 1'b1, 2'd3, 1'b1, 2'd3);
    cyc(2'b00, '0, '0, '0, 1'b1, 2'd3, 1'b1, 2'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_a", data_out_a, 16'h0000);
    check_eq("async_rst_b", data_out_b, 16'h0000);
    #1 rst = 1'b0;
    model_clear();
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(2'b00, '0, '0, '0, 1'b1, ADDR_W'(i), 1'b1, ADDR_W'(DEPTH - 1 - i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
